// File: rtl/zbt_addr_ctrl_out_pkg.sv
// Shared defaults and FSM encoding for the ZBT address/control output stage.
// No logic here: the package holds only constants and types.
// Imported by the top module of the block.
package zbt_addr_ctrl_out_pkg;

    localparam int ZBT_ADDR_BITS = 16;
    localparam int ZBT_LEN_BITS  = 4;
    localparam int ZBT_WR_LAT    = 2;
    localparam int ZBT_RD_LAT    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/zbt_addr_ctrl_out_if.sv
// Command handshake plus SRAM-side address/control and strobe bundle.
// master = arbiter side, which issues commands and observes the pins and strobes.
// slave  = zbt_addr_ctrl_out, which accepts commands and drives the pins and strobes.
interface zbt_addr_ctrl_out_if #(
    parameter int ADDR_BITS = 16,
    parameter int LEN_BITS  = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [LEN_BITS-1:0]  cmd_len;
    logic                 cmd_we;
    logic [ADDR_BITS-1:0] addr;
    logic                 ce_n;
    logic                 we_n;
    logic                 wr_data_en;
    logic                 rd_data_valid;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_we,
        input  cmd_ready, addr, ce_n, we_n, wr_data_en, rd_data_valid, busy
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_we,
        output cmd_ready, addr, ce_n, we_n, wr_data_en, rd_data_valid, busy
    );
endinterface

// File: rtl/zbt_addr_ctrl_out_strobe_delay.sv
// Fixed-depth single-bit shift register used to align data strobes with the SRAM pipeline.
// Latency: DEPTH cycles from din to dout.
// No backpressure: the register shifts every cycle, and clr_n flushes it asynchronously.
module zbt_strobe_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic dout,
    output logic pending
);
    logic [DEPTH-1:0] pipe_q;

    // Shift in one beat flag per cycle; the oldest flag falls out of the top.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | DEPTH'(din);
        end
    end

    assign dout    = pipe_q[DEPTH-1];
    assign pending = |pipe_q;
endmodule

// File: rtl/zbt_addr_ctrl_out.sv
// ZBT SRAM address/control output stage: burst commands in, one registered address/ce_n/we_n beat per cycle out.
// Latency: the first beat reaches the pins 1 cycle after accept; wr_data_en follows by WR_LAT cycles and rd_data_valid by RD_LAT cycles.
// Backpressure: cmd_ready is high only in IDLE or on the last beat of a burst. Define ZBT_BURST_WRAP_EN for aligned wrapped bursts.
module zbt_addr_ctrl_out
    import zbt_addr_ctrl_out_pkg::*;
#(
    parameter int ADDR_BITS = ZBT_ADDR_BITS,
    parameter int LEN_BITS  = ZBT_LEN_BITS,
    parameter int WR_LAT    = ZBT_WR_LAT,
    parameter int RD_LAT    = ZBT_RD_LAT
) (
    input  logic                fpga_clk,
    input  logic                reset_n,
    zbt_addr_ctrl_out_if.slave  bus
);
    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_BITS-1:0]  beats_q, beats_d;
    logic                 cur_we_q, cur_we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 ce_n_q, ce_n_d;
    logic                 we_n_q, we_n_d;
    logic                 ready;
    logic                 wr_beat, rd_beat;
    logic                 wr_en, rd_vld;
    logic                 wr_pend, rd_pend;

    // Address advance within a burst. Wrapped mode keeps the aligned block and rolls only the low LEN_BITS bits.
    function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
`ifdef ZBT_BURST_WRAP_EN
        next_addr = {a[ADDR_BITS-1:LEN_BITS], a[LEN_BITS-1:0] + LEN_BITS'(1)};
`else
        next_addr = a + ADDR_BITS'(1);
`endif
    endfunction

    // Hold the FSM state register.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compute the next state, the burst bookkeeping and the next pin values.
    // An accept on the last beat overrides the return to IDLE, so bursts run back to back.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        beats_d    = beats_q;
        cur_we_d   = cur_we_q;
        addr_d     = addr_q;
        ce_n_d     = 1'b1;
        we_n_d     = 1'b1;
        ready      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_BURST: begin
                ce_n_d     = 1'b0;
                we_n_d     = ~cur_we_q;
                addr_d     = cur_addr_q;
                cur_addr_d = next_addr(cur_addr_q);
                beats_d    = beats_q - LEN_BITS'(1);
                if (beats_q == '0) begin
                    ready   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (ready && bus.cmd_valid) begin
            state_d    = ST_BURST;
            cur_addr_d = bus.cmd_addr;
            beats_d    = bus.cmd_len;
            cur_we_d   = bus.cmd_we;
        end
    end

    // Register the burst context and the SRAM pins.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_q <= '0;
            beats_q    <= '0;
            cur_we_q   <= 1'b0;
            addr_q     <= '0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            cur_addr_q <= cur_addr_d;
            beats_q    <= beats_d;
            cur_we_q   <= cur_we_d;
            addr_q     <= addr_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
        end
    end

    // The delay lines are fed from the registered pins, so each strobe is
    // timed from the cycle its beat is actually visible at the SRAM.
    assign wr_beat = !ce_n_q && !we_n_q;
    assign rd_beat = !ce_n_q &&  we_n_q;

    zbt_strobe_delay #(.DEPTH(WR_LAT)) u_wr_delay (
        .clk     (fpga_clk),
        .clr_n   (reset_n),
        .din     (wr_beat),
        .dout    (wr_en),
        .pending (wr_pend)
    );

    zbt_strobe_delay #(.DEPTH(RD_LAT)) u_rd_delay (
        .clk     (fpga_clk),
        .clr_n   (reset_n),
        .din     (rd_beat),
        .dout    (rd_vld),
        .pending (rd_pend)
    );

    assign bus.cmd_ready     = ready;
    assign bus.addr          = addr_q;
    assign bus.ce_n          = ce_n_q;
    assign bus.we_n          = we_n_q;
    assign bus.wr_data_en    = wr_en;
    assign bus.rd_data_valid = rd_vld;
    // The beat currently on the pins has not yet entered a delay line, so it counts as pending work too.
    assign bus.busy          = (state_q == ST_BURST) || !ce_n_q || wr_pend || rd_pend;
endmodule

// File: tb/tb_zbt_addr_ctrl_out.sv
// Directed bench for zbt_addr_ctrl_out, using hand-computed per-cycle expectations.
// Snapshot layout: {addr[15:0], ce_n, we_n, wr_data_en, rd_data_valid, busy, cmd_ready}.
// Build with ZBT_BURST_WRAP_EN defined to check the wrapped-burst address order.
module tb_zbt_addr_ctrl_out;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    zbt_addr_ctrl_out_if #(.ADDR_BITS(16), .LEN_BITS(4)) bus ();

    zbt_addr_ctrl_out dut (
        .fpga_clk (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    function automatic logic [21:0] snap();
        snap = {bus.addr, bus.ce_n, bus.we_n, bus.wr_data_en, bus.rd_data_valid, bus.busy, bus.cmd_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_we    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = snap();
        vectors++;
        if (obs[21:1] !== {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_held got=%h want=%h", obs[21:1], {16'h0000, 5'b11000});
        end
        rst_n = 1'b1;
        tick();
        obs = snap();
        vectors++;
        if (obs !== {16'h0000, 6'b110001}) begin
            miscompares++;
            $display("FAIL reset_idle got=%h want=%h", obs, {16'h0000, 6'b110001});
        end
    endtask

    task automatic test_write_burst();
        logic [21:0] obs, exp;
        logic [15:0] ea;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 16'h1230;
        bus.cmd_len   = 4'd3;
        bus.cmd_we    = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ea  = (k <= 4) ? 16'(16'h1230 + k - 1) : 16'h1233;
            exp = {ea, (k > 4), (k > 4), (k >= 3 && k <= 6), 1'b0, (k <= 6), (k >= 3)};
            obs = snap();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL write_burst cycle %0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_read_wrap_boundary();
        logic [21:0] obs, exp;
        logic [15:0] alist [1:4];
        logic [15:0] ea;
        alist[1] = 16'hFFFE;
        alist[2] = 16'hFFFF;
`ifdef ZBT_BURST_WRAP_EN
        alist[3] = 16'hFFF0;
        alist[4] = 16'hFFF1;
`else
        alist[3] = 16'h0000;
        alist[4] = 16'h0001;
`endif
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 16'hFFFE;
        bus.cmd_len   = 4'd3;
        bus.cmd_we    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ea  = (k <= 4) ? alist[k] : alist[4];
            exp = {ea, (k > 4), 1'b1, 1'b0, (k >= 4 && k <= 7), (k <= 7), (k >= 3)};
            obs = snap();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL read_boundary cycle %0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] obs;
        logic [21:0] tab [1:7];
        tab[1] = {16'h0100, 6'b000011};
        tab[2] = {16'h0101, 6'b000011};
        tab[3] = {16'h0200, 6'b011011};
        tab[4] = {16'h0200, 6'b111011};
        tab[5] = {16'h0200, 6'b110011};
        tab[6] = {16'h0200, 6'b110111};
        tab[7] = {16'h0200, 6'b110001};
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 16'h0100;
        bus.cmd_len   = 4'd1;
        bus.cmd_we    = 1'b1;
        tick();
        bus.cmd_addr  = 16'h0200;
        bus.cmd_len   = 4'd0;
        bus.cmd_we    = 1'b0;
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_mid got=%b want=0", bus.cmd_ready);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) bus.cmd_valid = 1'b0;
            obs = snap();
            vectors++;
            if (obs !== tab[k]) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d got=%h want=%h", k, obs, tab[k]);
            end
        end
    endtask

    task automatic test_max_len();
        int beats = 0;
        int rds = 0;
        int first_rd = -1;
        logic [15:0] last_addr = '0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 16'h0010;
        bus.cmd_len   = 4'hF;
        bus.cmd_we    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (bus.ce_n === 1'b0) begin
                beats++;
                last_addr = bus.addr;
            end
            if (bus.rd_data_valid === 1'b1) begin
                rds++;
                if (first_rd < 0) first_rd = k;
            end
        end
        vectors++;
        if (beats != 16) begin
            miscompares++;
            $display("FAIL maxlen_beats got=%0d want=16", beats);
        end
        vectors++;
        if (rds != 16) begin
            miscompares++;
            $display("FAIL maxlen_rd_count got=%0d want=16", rds);
        end
        vectors++;
        if (last_addr !== 16'h001F) begin
            miscompares++;
            $display("FAIL maxlen_last_addr got=%h want=001f", last_addr);
        end
        vectors++;
        if (first_rd != 4) begin
            miscompares++;
            $display("FAIL maxlen_first_rd got=%0d want=4", first_rd);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [21:0] obs;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 16'h4000;
        bus.cmd_len   = 4'd7;
        bus.cmd_we    = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        obs = snap();
        vectors++;
        if (obs[21:4] !== {16'h4001, 2'b00}) begin
            miscompares++;
            $display("FAIL midrst_beat2 got=%h want=%h", obs[21:4], {16'h4001, 2'b00});
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = snap();
        vectors++;
        if (obs !== {16'h0000, 6'b110001}) begin
            miscompares++;
            $display("FAIL midrst_async got=%h want=%h", obs, {16'h0000, 6'b110001});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            obs = snap();
            vectors++;
            if (obs !== {16'h0000, 6'b110001}) begin
                miscompares++;
                $display("FAIL midrst_after cycle %0d got=%h want=%h", k, obs, {16'h0000, 6'b110001});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap_boundary();
        test_back_to_back();
        test_max_len();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
